// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states, iteration count.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_NOT = 4'd2,
        OP_MUL = 4'd3,
        OP_DIV = 4'd4,
        OP_SRL = 4'd5,
        OP_SLL = 4'd6,
        OP_ADD = 4'd7,
        OP_SUB = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_e;

    // One product/quotient bit per cycle.
    function automatic int iter_count(input int width);
        return width;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Handshake and result bus between operand fetch, the sequential ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             dz;
    logic             err;

    modport master (output in_valid, a, b, op, out_ready,
                    input  in_ready, out_valid, y, y_hi, zero, carry, ovf, dz, err);
    modport slave  (input  in_valid, a, b, op, out_ready,
                    output in_ready, out_valid, y, y_hi, zero, carry, ovf, dz, err);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared iterative engine: radix-2 shift-add multiply and restoring divide.
// {hi,lo} holds the running product/remainder+quotient; nxt_* is the next step.
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_mode,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int ITER = iter_count(WIDTH);

    logic [SHW-1:0] cnt;
    logic           mode;
    logic [WIDTH-1:0] hi, lo, d;
    logic [WIDTH:0] mul_sum, div_sh, div_diff;

    assign last = run && (cnt == '0);

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        div_sh   = {hi, lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, d};
        if (!mode) begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            nxt_hi = div_diff[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], 1'b1};
        end else begin
            nxt_hi = div_sh[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // lo starts as multiplier / dividend, d holds multiplicand / divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            mode <= 1'b0;
            hi   <= '0;
            lo   <= '0;
            d    <= '0;
        end else if (start) begin
            cnt  <= SHW'(ITER - 1);
            mode <= div_mode;
            hi   <= '0;
            lo   <= a;
            d    <= b;
        end else if (run) begin
            cnt  <= cnt - 1'b1;
            hi   <= nxt_hi;
            lo   <= nxt_lo;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes; single-cycle logic/shift/add ops
// and WIDTH-cycle multiply/divide through alu_muldiv_iter.
module alu_seq import alu_pkg::*; #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    state_e           state;
    logic             accept, start, last;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH:0]   add_r;
    logic [WIDTH-1:0] b_neg, r_y, r_hi;
    logic             r_c, r_v, r_dz, r_err;

    assign bus.in_ready = !rst && (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign start        = accept && ((bus.op == OP_MUL) || (bus.op == OP_DIV && bus.b != '0));

    always_comb begin
        add_r = {1'b0, bus.a} + {1'b0, bus.b};
        b_neg = ~bus.b + 1'b1;
        r_y   = '0;
        r_hi  = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        r_dz  = 1'b0;
        r_err = 1'b0;
        case (bus.op)
            OP_AND: r_y = bus.a & bus.b;
            OP_OR:  r_y = bus.a | bus.b;
            OP_NOT: r_y = ~bus.a;
            OP_MUL: r_y = '0;
            // Only reaches the output on divide-by-zero; otherwise the iterator owns it.
            OP_DIV: begin
                r_y  = '1;
                r_hi = bus.a;
                r_dz = 1'b1;
            end
            OP_SRL: r_y = bus.a >> bus.b[SHW-1:0];
            OP_SLL: r_y = bus.a << bus.b[SHW-1:0];
            OP_ADD: begin
                r_y = add_r[WIDTH-1:0];
                r_c = add_r[WIDTH];
                r_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                r_y = bus.a + b_neg;
                r_c = bus.a < bus.b;
                r_v = (bus.a[WIDTH-1] == b_neg[WIDTH-1]) && (r_y[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: r_err = 1'b1;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .div_mode (bus.op == OP_DIV),
        .run      (state != IDLE),
        .a        (bus.a),
        .b        (bus.b),
        .last     (last),
        .nxt_hi   (it_hi),
        .nxt_lo   (it_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.y_hi      <= '0;
            bus.zero      <= 1'b0;
            bus.carry     <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.dz        <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            if (bus.out_ready) bus.out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (start) begin
                        if (bus.op == OP_MUL) state <= MUL;
                        else                  state <= DIV;
                    end else begin
                        bus.out_valid <= 1'b1;
                        bus.y         <= r_y;
                        bus.y_hi      <= r_hi;
                        bus.zero      <= (r_y == '0);
                        bus.carry     <= r_c;
                        bus.ovf       <= r_v;
                        bus.dz        <= r_dz;
                        bus.err       <= r_err;
                    end
                end
                // Slot was free when we left IDLE, so completion can always write.
                default: if (last) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b1;
                    bus.y         <= it_lo;
                    bus.y_hi      <= it_hi;
                    bus.zero      <= (it_lo == '0);
                    bus.carry     <= 1'b0;
                    bus.ovf       <= 1'b0;
                    bus.dz        <= 1'b0;
                    bus.err       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors with literal expectations plus an
// arithmetic reference model feeding a scoreboard checked on every handshake.
module tb_alu_seq;
    localparam int W = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [W-1:0] y;
        logic [W-1:0] hi;
        logic zero, carry, ovf, dz, err;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rnd_rdy = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    res_t q[$];
    res_t held, e;
    logic hold_v = 1'b0;

    logic [3:0]   vop [14] = '{4'd7, 4'd3, 4'd8, 4'd4, 4'd12, 4'd5, 4'd4, 4'd6, 4'd0, 4'd1, 4'd2, 4'd15, 4'd7, 4'd8};
    logic [W-1:0] va  [14] = '{32'd5, 32'd123456, 32'd10, 32'd1000, 32'd1, 32'hF000_0000, 32'd55,
                               32'd3, 32'hDEAD_BEEF, 32'h1200_0034, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] vb  [14] = '{32'd9, 32'd789, 32'd3, 32'd33, 32'd1, 32'd4, 32'd0,
                               32'd33, 32'h0F0F_0F0F, 32'h0056_7800, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic res_t cur();
        return {bus.y, bus.y_hi, bus.zero, bus.carry, bus.ovf, bus.dz, bus.err};
    endfunction

    function automatic res_t mk(input logic [W-1:0] y, input logic [W-1:0] hi,
                                input logic c, input logic v, input logic d, input logic er);
        res_t r;
        r.y = y; r.hi = hi; r.zero = (y == 0); r.carry = c; r.ovf = v; r.dz = d; r.err = er;
        return r;
    endfunction

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        logic [63:0] p;
        logic [W-1:0] bn;
        longint ss;
        int sh;
        r = '0;
        sh = int'(b % W);
        case (op)
            4'd0: r.y = a & b;
            4'd1: r.y = a | b;
            4'd2: r.y = ~a;
            4'd3: begin p = 64'(a) * 64'(b); r.y = p[31:0]; r.hi = p[63:32]; end
            4'd4: if (b == 0) begin r.y = '1; r.hi = a; r.dz = 1'b1; end
                  else begin r.y = a / b; r.hi = a % b; end
            4'd5: begin p = 64'(a) / (64'd1 << sh); r.y = p[31:0]; end
            4'd6: begin p = 64'(a) * (64'd1 << sh); r.y = p[31:0]; end
            4'd7: begin
                r.y = a + b;
                r.carry = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                ss = longint'($signed(a)) + longint'($signed(b));
                r.ovf = (ss > SMAX) || (ss < SMIN);
            end
            4'd8: begin
                bn = -b;
                r.y = a - b;
                r.carry = a < b;
                ss = longint'($signed(a)) + longint'($signed(bn));
                r.ovf = (ss > SMAX) || (ss < SMIN);
            end
            default: r.err = 1'b1;
        endcase
        r.zero = (r.y == 0);
        return r;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkr(input string nm, input res_t act, input res_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got y=%h hi=%h zcvde=%b%b%b%b%b expected y=%h hi=%h zcvde=%b%b%b%b%b",
                     nm, act.y, act.hi, act.zero, act.carry, act.ovf, act.dz, act.err,
                     exp.y, exp.hi, exp.zero, exp.carry, exp.ovf, exp.dz, exp.err);
        end
    endtask

    // Compare process: hold stability, then scoreboard pop on handshake, then push on accept.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk1("hold_out_valid", bus.out_valid, 1'b1);
                chkr("hold_data", cur(), held);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chkw("sb_underflow", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chkr("sb_result", cur(), e);
                end
            end
            hold_v = bus.out_valid && !bus.out_ready;
            held = cur();
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.op, bus.a, bus.b));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called just after a posedge; returns just after the acceptance edge.
    task automatic send(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!ok) chkw("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic do_op(input string nm, input logic [3:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input int explat, input res_t exp);
        int lat;
        @(posedge clk);
        #1;
        send(o, av, bv);
        wait_out(lat);
        chkw({nm, "_lat"}, 32'(lat), 32'(explat));
        chkr(nm, cur(), exp);
    endtask

    initial begin
        int lat;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;

        @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chkr("rst_outputs", cur(), '0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk1("idle_in_ready", bus.in_ready, 1'b1);

        do_op("add_ovf",  4'd7, 32'h7FFF_FFFF, 32'd1, 1, mk(32'h8000_0000, 0, 1'b0, 1'b1, 1'b0, 1'b0));
        do_op("add_wrap", 4'd7, 32'hFFFF_FFFF, 32'd1, 1, mk(32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        do_op("sub_neg",  4'd8, 32'd3, 32'd5, 1, mk(32'hFFFF_FFFE, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        do_op("srl_35",   4'd5, 32'h8000_0000, 32'd35, 1, mk(32'h1000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_op("sll_31",   4'd6, 32'd1, 32'd31, 1, mk(32'h8000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_op("srl_0",    4'd5, 32'h1234_5678, 32'd32, 1, mk(32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_op("not_0",    4'd2, 32'd0, 32'd0, 1, mk(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_op("undef_12", 4'd12, 32'h55, 32'h66, 1, mk(32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
        do_op("div_100_7", 4'd4, 32'd100, 32'd7, 33, mk(32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        do_op("div_by_0",  4'd4, 32'd100, 32'd0, 1, mk(32'hFFFF_FFFF, 32'd100, 1'b0, 1'b0, 1'b1, 1'b0));
        do_op("mul_ff_2",  4'd3, 32'hFFFF_FFFF, 32'd2, 33, mk(32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0));

        // MUL with back-pressure; a queued AND must wait for the handshake.
        @(posedge clk); #1;
        send(4'd3, 32'hFFFF_FFFF, 32'd2);
        bus.out_ready = 1'b0;
        wait_out(lat);
        chkw("mul_bp_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.in_valid = 1'b1; bus.op = 4'd0; bus.a = 32'hF0F0_1234; bus.b = 32'h0FF0_FFFF;
            end
            @(negedge clk);
            chkw("mul_bp_y", bus.y, 32'hFFFF_FFFE);
            chkw("mul_bp_hi", bus.y_hi, 32'd1);
            chk1("mul_bp_in_ready", bus.in_ready, 1'b0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk1("bp_next_valid", bus.out_valid, 1'b1);
        chkw("bp_next_y", bus.y, 32'h00F0_1234);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        send(4'd3, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk1("midrst_valid", bus.out_valid, 1'b0);
        chkw("midrst_y", bus.y, 32'd0);
        do_op("post_rst_add", 4'd7, 32'd1, 32'd1, 1, mk(32'd2, 0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Throughput: ten back-to-back ANDs, drained every cycle.
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.op = 4'd0;
        for (int i = 0; i < 10; i++) begin
            bus.a = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_5A5A;
            bus.b = ~(32'(i) << 4);
            @(negedge clk);
            chk1("tp_in_ready", bus.in_ready, 1'b1);
            if (i > 0) chk1("tp_out_valid", bus.out_valid, 1'b1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk1("tp_last_valid", bus.out_valid, 1'b1);
        @(negedge clk);
        chk1("tp_drained", bus.out_valid, 1'b0);

        // Vector table twice over with a random consumer.
        @(posedge clk); #1;
        rnd_rdy = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 14; i++)
                send(vop[i], va[i], vb[i] + 32'(r));
        rnd_rdy = 1'b0;
        @(posedge clk); #2 bus.out_ready = 1'b1;
        lat = 0;
        while ((q.size() != 0 || bus.out_valid) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chkw("drain_queue_empty", 32'(q.size()), 32'd0);
        chk1("drain_out_valid", bus.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 32-bit ALU.
- Adds valid/ready handshakes on input and output, iterative multi-cycle multiply and divide, variable shift amounts, add/sub, and status flags.
- Sits between the decode/operand-fetch stage and writeback of the datapath; back-pressure from writeback stalls the unit.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and op are valid this cycle
- in_ready  output  1  unit can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; shift amount = b[SHW-1:0]
- op  input  4  operation code (see Behaviour)
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts the result
- y  output  WIDTH  primary result
- y_hi  output  WIDTH  MUL: high half of product; DIV: remainder; other ops: 0
- zero  output  1  y == 0
- carry  output  1  ADD carry-out / SUB borrow (a < b unsigned); 0 for other ops
- ovf  output  1  ADD/SUB signed overflow; 0 for other ops
- dz  output  1  DIV with b == 0
- err  output  1  undefined op code

Behaviour:
- Op codes:
  - 0 AND
  - 1 OR
  - 2 NOT (~a)
  - 3 MUL (unsigned, 2*WIDTH product)
  - 4 DIV (unsigned)
  - 5 SRL (a >> b[SHW-1:0])
  - 6 SLL (a << b[SHW-1:0])
  - 7 ADD
  - 8 SUB (a - b)
  - 9-15 undefined
- Reset: state=IDLE; out_valid, y, y_hi and all flags = 0; in_ready = 0 during the reset cycle. Reset mid-operation aborts the operation and discards partial results.
- Accept: an operation is accepted when in_valid && in_ready. Operands and op are captured on acceptance; later changes to the inputs have no effect.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Issuing back-to-back single-cycle ops while the output is drained every cycle gives 1 result per cycle.
- Single-cycle ops (0,1,2,5,6,7,8 and undefined): result is registered at the acceptance edge, so out_valid rises 1 cycle after acceptance.
- Undefined op: y=0, y_hi=0, err=1, other flags 0.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL when op 3 is accepted.
  - IDLE -> DIV when op 4 is accepted and b != 0.
  - MUL/DIV -> IDLE after WIDTH iteration cycles, with the result written at the final iteration edge. out_valid rises WIDTH+1 cycles after acceptance.
- MUL: radix-2 shift-add, one bit per cycle. Output y = product[WIDTH-1:0], y_hi = product[2W-1:W].
- DIV: restoring division, one quotient bit per cycle. Output y = quotient, y_hi = remainder.
- DIV by zero: handled as a single-cycle op with no iteration. Output y = all ones, y_hi = a, dz=1.
- Output hold: while out_valid && !out_ready, y, y_hi and flags are stable and no new op is accepted. out_valid drops on the handshake edge unless a new single-cycle result is written on the same edge, in which case it stays high with the new data.
- Multi-cycle completion: the FSM only leaves IDLE when the output slot is free, so a completing MUL/DIV always finds the slot free.
- Shifts: shift amount >= WIDTH is impossible by construction (SHW bits). Shift by 0 returns a.
- ADD/SUB widths: computed in WIDTH+1 bits.
  - carry = bit WIDTH for ADD; carry = borrow for SUB.
  - ovf = sign(a)==sign(b') && sign(y)!=sign(a), where b' = b for ADD and ~b+1 for SUB.
- zero is computed on y only, for every op.

Decomposition:
- Package alu_pkg holds:
  - op_e enum: OP_AND=0, OP_OR=1, OP_NOT=2, OP_MUL=3, OP_DIV=4, OP_SRL=5, OP_SLL=6, OP_ADD=7, OP_SUB=8.
  - state_e enum: IDLE, MUL, DIV.
  - Localparam function for the iteration count.
- One sub-module, alu_muldiv_iter, holds the shared iteration counter and the shift/accumulate registers for MUL and DIV, selected by a mode bit. alu_seq keeps the handshake, the single-cycle datapath and the output registers.

Test Plan (WIDTH=32):
- Reset mid-MUL: a=7, b=6, assert rst at cycle 10 -> out_valid=0, y=0 next cycle. A subsequent ADD 1+1 gives y=2 after 1 cycle.
- MUL with back-pressure:
  - a=0xFFFFFFFF, b=2, out_ready=1 -> out_valid at cycle 33, y=0xFFFFFFFE, y_hi=1.
  - Repeat with out_ready=0 for 5 cycles -> y held stable and in_ready=0 until the handshake.
- DIV:
  - a=100, b=7 -> y=14, y_hi=2 after 33 cycles, dz=0.
  - a=100, b=0 -> y=0xFFFFFFFF, y_hi=100, dz=1 after 1 cycle.
- ADD/SUB flags:
  - ADD 0x7FFFFFFF+1 -> y=0x80000000, ovf=1, carry=0.
  - ADD 0xFFFFFFFF+1 -> y=0, zero=1, carry=1, ovf=0.
  - SUB 3-5 -> y=0xFFFFFFFE, carry=1.
- Shifts and logic:
  - SRL a=0x80000000, b=35 -> shift by 3, y=0x10000000.
  - SLL a=1, b=31 -> y=0x80000000.
  - NOT 0 -> y=0xFFFFFFFF.
  - op=12 -> err=1, y=0.
- Throughput: 10 back-to-back ANDs with out_ready=1 -> 10 results in 10 consecutive cycles with in_ready constantly 1. A random out_ready pattern must lose and duplicate no results (checked against a scoreboard).
